// File: rtl/fetch_control_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_control_pkg;

   typedef enum logic [2:0] {
      FILL     = 3'd0,
      RUN      = 3'd1,
      DRAIN    = 3'd2,
      REDIRECT = 3'd3,
      HALT     = 3'd4
   } fetch_state_t;

   localparam logic [3:0]  OPC_HALT = 4'hF;
   localparam logic [23:0] NOP_WORD = 24'h00_0000;

   // True when the opcode field stops the fetch stream.
   function automatic logic is_halt_opc(input logic [3:0] opc);
      return (opc == OPC_HALT);
   endfunction

endpackage

// File: rtl/fetch_control_pc_reg.sv
// Program counter register: load has priority over increment, otherwise hold.
// Increment wraps modulo 2**W.
module fetch_control_pc_reg #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   output logic [W-1:0] pc_o
);

   logic [W-1:0] pc_q;

   // PC update: reset, redirect/rewind load, sequential increment or hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= '0;
      end else if (load_i) begin
         pc_q <= load_val_i;
      end else if (inc_i) begin
         pc_q <= pc_q + W'(1);
      end else begin
         pc_q <= pc_q;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_control.sv
// Fetch controller: owns the PC, drives a 1-cycle synchronous instruction ROM,
// squashes wrong-path words after a decoded branch and follows write-back redirects.
module fetch_control
   import fetch_control_pkg::*;
#(
   parameter int unsigned instructionSize = 24,
   parameter int unsigned pcSize          = 32,
   parameter int unsigned memDepth        = 256,
   parameter int unsigned flushCycles     = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        branchDec,
   input  logic                        pcWrEn,
   input  logic [pcSize-1:0]           newPc,
   input  logic [instructionSize-1:0]  imemData,
   output logic [$clog2(memDepth)-1:0] imemAddr,
   output logic [instructionSize-1:0]  instruction,
   output logic                        instrValid,
   output logic [pcSize-1:0]           pcOut,
   output logic                        halted
);

   localparam int unsigned AW = $clog2(memDepth);
   localparam int unsigned CW = $clog2(flushCycles + 1);

   fetch_state_t                 state_q;
   logic [pcSize-1:0]            fetch_pc_q;
   logic [instructionSize-1:0]   instr_q;
   logic                         valid_q;
   logic [pcSize-1:0]            pc_out_q;
   logic                         halted_q;
   logic [CW-1:0]                cnt_q;
   // The ROM has no read enable, so while stalled it moves on to the next
   // address; the word that was on imemData when the stall began is kept here.
   logic [instructionSize-1:0]   hold_q;
   logic                         hold_vld_q;

   logic [pcSize-1:0]            pc_s;
   logic                         pc_load_s;
   logic [pcSize-1:0]            pc_load_val_s;
   logic                         pc_inc_s;
   logic                         redirect_s;
   logic [instructionSize-1:0]   data_sel_s;

   assign redirect_s = pcWrEn && (state_q != HALT);
   assign data_sel_s = hold_vld_q ? hold_q : imemData;

   // PC control mirrors the FSM priorities: redirect > branch rewind > stall > advance.
   always_comb begin
      pc_load_s     = 1'b0;
      pc_load_val_s = pc_s;
      pc_inc_s      = 1'b0;
      if (redirect_s) begin
         pc_load_s     = 1'b1;
         pc_load_val_s = newPc;
      end else begin
         case (state_q)
            FILL, REDIRECT: pc_inc_s = !stall;
            RUN: begin
               if (branchDec) begin
                  pc_load_s     = 1'b1;
                  pc_load_val_s = fetch_pc_q;
               end else begin
                  pc_inc_s = !stall;
               end
            end
            default: begin
               pc_inc_s = 1'b0;
            end
         endcase
      end
   end

   fetch_control_pc_reg #(.W(pcSize)) u_pc_reg (
      .clk        (clk),
      .reset      (reset),
      .load_i     (pc_load_s),
      .load_val_i (pc_load_val_s),
      .inc_i      (pc_inc_s),
      .pc_o       (pc_s)
   );

   // Fetch FSM with registered pipe outputs, squash and drain counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FILL;
         fetch_pc_q <= '0;
         instr_q    <= instructionSize'(NOP_WORD);
         valid_q    <= 1'b0;
         pc_out_q   <= '0;
         halted_q   <= 1'b0;
         cnt_q      <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else if (redirect_s) begin
         instr_q    <= instructionSize'(NOP_WORD);
         valid_q    <= 1'b0;
         cnt_q      <= '0;
         hold_vld_q <= 1'b0;
         state_q    <= (state_q == DRAIN) ? REDIRECT : FILL;
      end else begin
         case (state_q)
            FILL, REDIRECT: begin
               instr_q <= instructionSize'(NOP_WORD);
               valid_q <= 1'b0;
               if (!stall) begin
                  fetch_pc_q <= pc_s;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               if (branchDec) begin
                  instr_q    <= instructionSize'(NOP_WORD);
                  valid_q    <= 1'b0;
                  cnt_q      <= CW'(flushCycles - 1);
                  hold_vld_q <= 1'b0;
                  state_q    <= DRAIN;
               end else if (stall) begin
                  if (!hold_vld_q) begin
                     hold_q     <= imemData;
                     hold_vld_q <= 1'b1;
                  end
               end else begin
                  instr_q    <= data_sel_s;
                  valid_q    <= 1'b1;
                  pc_out_q   <= fetch_pc_q;
                  fetch_pc_q <= pc_s;
                  hold_vld_q <= 1'b0;
                  if (is_halt_opc(data_sel_s[instructionSize-1 -: 4])) begin
                     halted_q <= 1'b1;
                     state_q  <= HALT;
                  end
               end
            end
            DRAIN: begin
               instr_q <= instructionSize'(NOP_WORD);
               valid_q <= 1'b0;
               if (cnt_q == CW'(0)) begin
                  state_q <= FILL;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            HALT: begin
               instr_q  <= instructionSize'(NOP_WORD);
               valid_q  <= 1'b0;
               halted_q <= 1'b1;
            end
            default: begin
               instr_q <= instructionSize'(NOP_WORD);
               valid_q <= 1'b0;
               state_q <= FILL;
            end
         endcase
      end
   end

   assign imemAddr    = pc_s[AW-1:0];
   assign instruction = instr_q;
   assign instrValid  = valid_q;
   assign pcOut       = pc_out_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: table-driven per-cycle vectors plus a scoreboard of
// expected fetched words, with hand sequences for wrap, collision and HALT.
module tb_fetch_control;

   localparam int IW = 24;
   localparam int PW = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall;
   logic          branchDec;
   logic          pcWrEn;
   logic [PW-1:0] newPc;
   logic [IW-1:0] imemData;
   logic [AW-1:0] imemAddr;
   logic [IW-1:0] instruction;
   logic          instrValid;
   logic [PW-1:0] pcOut;
   logic          halted;

   logic [IW-1:0] rom [0:255];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic          rst;
      logic          stl;
      logic          bd;
      logic          pw;
      logic [PW-1:0] npc;
      logic          ev;
      logic [PW-1:0] epc;
      logic          eh;
   } vec_t;

   typedef struct {
      logic [IW-1:0] ins;
      logic [PW-1:0] pc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   fetch_control dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .branchDec   (branchDec),
      .pcWrEn      (pcWrEn),
      .newPc       (newPc),
      .imemData    (imemData),
      .imemAddr    (imemAddr),
      .instruction (instruction),
      .instrValid  (instrValid),
      .pcOut       (pcOut),
      .halted      (halted)
   );

   // Synchronous ROM, one cycle of read latency.
   always @(posedge clk) imemData <= rom[imemAddr];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Scoreboard: every valid word must match the next expected one.
   always @(negedge clk) begin
      if (instrValid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: valid word at pcOut %0h, none expected", pcOut);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_instr", {8'h00, instruction}, {8'h00, e.ins});
            check("sb_pc", pcOut, e.pc);
         end
      end
   end

   task automatic add(input logic rst, input logic stl, input logic bd, input logic pw,
                      input logic [PW-1:0] npc, input logic ev, input logic [PW-1:0] epc,
                      input logic eh);
      vec_t v;
      v.rst = rst; v.stl = stl; v.bd = bd; v.pw = pw;
      v.npc = npc; v.ev = ev; v.epc = epc; v.eh = eh;
      vecs.push_back(v);
   endtask

   task automatic step(input vec_t v);
      @(negedge clk);
      reset     = v.rst;
      stall     = v.stl;
      branchDec = v.bd;
      pcWrEn    = v.pw;
      newPc     = v.npc;
      if (v.ev) begin
         exp_t e;
         e.ins = rom[v.epc[AW-1:0]];
         e.pc  = v.epc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      check("instrValid", {31'h0, instrValid}, {31'h0, v.ev});
      check("halted", {31'h0, halted}, {31'h0, v.eh});
      if (v.ev) check("pcOut", pcOut, v.epc);
      else      check("bubble_zero", {8'h00, instruction}, 32'h0);
   endtask

   task automatic run_table();
      foreach (vecs[i]) step(vecs[i]);
      vecs.delete();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[i] = {4'(1 + (i % 14)), 12'h5A0 ^ 12'(i * 7), 8'(i)};
      end
      reset = 1'b1; stall = 1'b0; branchDec = 1'b0; pcWrEn = 1'b0; newPc = 32'h0;

      // 1: reset then sequential A,B,C,D
      add(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      run_table();
      check("reset_pcOut", pcOut, 32'h0);
      check("reset_addr", {24'h0, imemAddr}, 32'h0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      for (int k = 0; k < 4; k++) add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'(k),1'b0);
      // 2: branch on word 2, redirect to 0x10 three cycles later
      add(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      for (int k = 0; k < 3; k++) add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'(k),1'b0);
      add(1'b0,1'b0,1'b1,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b1,32'h10, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h10,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h11,1'b0);
      // 3: branch not taken, stall during drain must not slow it
      add(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      for (int k = 0; k < 3; k++) add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'(k),1'b0);
      add(1'b0,1'b0,1'b1,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      for (int k = 3; k < 6; k++) add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'(k),1'b0);
      // 4: two-cycle stall mid-stream
      add(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h1,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,32'h0, 1'b1,32'h1,1'b0);
      add(1'b0,1'b1,1'b0,1'b0,32'h0, 1'b1,32'h1,1'b0);
      for (int k = 2; k < 5; k++) add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'(k),1'b0);
      run_table();

      // 5a: redirect to 255, ROM address wraps to 0
      add(1'b0,1'b0,1'b0,1'b1,32'hFF, 1'b0,32'h0,1'b0);
      run_table();
      check("addr_at_255", {24'h0, imemAddr}, 32'hFF);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      run_table();
      check("addr_wrap", {24'h0, imemAddr}, 32'h0);
      for (int k = 255; k < 258; k++) add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'(k),1'b0);
      // 5b: branchDec and pcWrEn together: redirect, no drain
      add(1'b0,1'b0,1'b1,1'b1,32'h40, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h40,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h41,1'b0);
      run_table();

      // 6: HALT word at address 5, then reset out of HALT
      rom[5] = 24'hF0_0005;
      add(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      for (int k = 0; k < 5; k++) add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'(k),1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h5,1'b1);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b1);
      add(1'b0,1'b0,1'b0,1'b1,32'h20, 1'b0,32'h0,1'b1);
      add(1'b0,1'b0,1'b1,1'b0,32'h0, 1'b0,32'h0,1'b1);
      add(1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b1);
      add(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      run_table();
      check("halt_reset_addr", {24'h0, imemAddr}, 32'h0);
      check("halt_reset_pcOut", pcOut, 32'h0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h1,1'b0);
      run_table();

      @(negedge clk);
      #1;
      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
